// File: rtl/cache_control_pkg.sv
// Shared types for the LC-3b L1 cache controller: address-field widths,
// datapath mux select encodings, controller states and victim selection.
package lc3b_ctypes;

  localparam int CTAG_W    = 9;
  localparam int CINDEX_W  = 3;
  localparam int COFFSET_W = 4;

  typedef logic [CTAG_W-1:0]    lc3b_ctag;
  typedef logic [CINDEX_W-1:0]  lc3b_cindex;
  typedef logic [COFFSET_W-1:0] lc3b_coffset;

  typedef enum logic {
    INMUX_PMEM = 1'b0,
    INMUX_CPU  = 1'b1
  } inmux_sel_t;

  typedef enum logic {
    HITMUX_WAY1 = 1'b0,
    HITMUX_WAY0 = 1'b1
  } hitmux_sel_t;

  typedef enum logic {
    PADDR_CPU    = 1'b0,
    PADDR_VICTIM = 1'b1
  } pmem_addr_sel_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } cache_state_t;

  // Empty ways are filled before anything valid is evicted; way 0 first.
  function automatic logic pick_victim(input logic valid0, input logic valid1,
                                       input logic lru);
    if (!valid0) return 1'b0;
    if (!valid1) return 1'b1;
    return lru;
  endfunction

  function automatic hitmux_sel_t way_to_hitmux(input logic way);
    return way ? HITMUX_WAY1 : HITMUX_WAY0;
  endfunction

endpackage

// File: rtl/cache_control_perf_counter.sv
// Saturating event counter: counts i_inc pulses, sticks at all-ones,
// clears on asynchronous reset.
module cache_perf_counter
  #(parameter int CNT_WIDTH = 16)
  (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_count
  );

  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_sat;

  assign w_sat   = &r_count;
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && !w_sat) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative LC-3b L1 cache: hit/miss detection,
// array write enables, dirty-victim writeback and line fill, event counters.
module cache_control
  import lc3b_ctypes::*;
  #(parameter int CNT_WIDTH = 16)
  (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [15:0]          mem_address,
    output logic                 mem_resp,
    input  logic                 hit0,
    input  logic                 hit1,
    input  logic                 valid_out0,
    input  logic                 valid_out1,
    input  logic                 dirty_out0,
    input  logic                 dirty_out1,
    input  logic                 lru_out,
    output logic [8:0]           cache_tag,
    output logic [2:0]           cache_index,
    output logic [3:0]           cache_offset,
    output logic                 inmux_sel,
    output logic                 hitmux_sel,
    output logic                 pmem_addr_sel,
    output logic                 data0_write,
    output logic                 data1_write,
    output logic                 tag0_write,
    output logic                 tag1_write,
    output logic                 valid0_write,
    output logic                 valid1_write,
    output logic                 dirty0_write,
    output logic                 dirty1_write,
    output logic                 lru_write,
    output logic                 lru_bit,
    output logic                 valid_bit,
    output logic                 dirty_bit,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count,
    output logic [1:0]           dbg_state
  );

  // Handshakes: the CPU holds mem_read/mem_write until the single-cycle
  // mem_resp; the controller holds pmem_read/pmem_write until pmem_resp.
  // pmem_resp outside WRITEBACK/FILL is ignored.

  lc3b_ctag     w_tag;
  lc3b_cindex   w_index;
  lc3b_coffset  w_offset;

  cache_state_t r_state;
  cache_state_t w_state_next;
  logic         r_victim;

  logic w_req;
  logic w_is_write;
  logic w_hit0;
  logic w_hit1;
  logic w_any_hit;
  logic w_victim;
  logic w_victim_dirty;
  logic w_hit_inc;
  logic w_miss_inc;
  logic w_wb_inc;

  assign w_tag        = mem_address[15:7];
  assign w_index      = mem_address[6:4];
  assign w_offset     = mem_address[3:0];
  assign cache_tag    = w_tag;
  assign cache_index  = w_index;
  assign cache_offset = w_offset;

  assign w_req      = mem_read | mem_write;
  assign w_is_write = mem_write;
  assign w_hit0     = hit0 & valid_out0;
  assign w_hit1     = hit1 & valid_out1;
  assign w_any_hit  = w_hit0 | w_hit1;

  assign w_victim       = pick_victim(valid_out0, valid_out1, lru_out);
  assign w_victim_dirty = w_victim ? (valid_out1 & dirty_out1)
                                   : (valid_out0 & dirty_out0);

  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_victim <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_miss_inc) begin
        r_victim <= w_victim;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    mem_resp      = 1'b0;
    inmux_sel     = INMUX_PMEM;
    hitmux_sel    = HITMUX_WAY1;
    pmem_addr_sel = PADDR_CPU;
    data0_write   = 1'b0;
    data1_write   = 1'b0;
    tag0_write    = 1'b0;
    tag1_write    = 1'b0;
    valid0_write  = 1'b0;
    valid1_write  = 1'b0;
    dirty0_write  = 1'b0;
    dirty1_write  = 1'b0;
    lru_write     = 1'b0;
    lru_bit       = 1'b0;
    valid_bit     = 1'b0;
    dirty_bit     = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    w_hit_inc     = 1'b0;
    w_miss_inc    = 1'b0;
    w_wb_inc      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_req && w_any_hit) begin
          // Way 0 wins if the datapath ever reports a double hit.
          mem_resp   = 1'b1;
          hitmux_sel = w_hit0 ? HITMUX_WAY0 : HITMUX_WAY1;
          lru_write  = 1'b1;
          lru_bit    = w_hit0;
          w_hit_inc  = 1'b1;
          if (w_is_write) begin
            inmux_sel    = INMUX_CPU;
            dirty_bit    = 1'b1;
            data0_write  = w_hit0;
            dirty0_write = w_hit0;
            data1_write  = !w_hit0;
            dirty1_write = !w_hit0;
          end
        end else if (w_req) begin
          w_miss_inc   = 1'b1;
          w_state_next = w_victim_dirty ? WRITEBACK : FILL;
        end
      end

      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = PADDR_VICTIM;
        hitmux_sel    = way_to_hitmux(r_victim);
        if (pmem_resp) begin
          w_wb_inc     = 1'b1;
          w_state_next = FILL;
        end
      end

      FILL: begin
        pmem_read     = 1'b1;
        pmem_addr_sel = PADDR_CPU;
        inmux_sel     = INMUX_PMEM;
        if (pmem_resp) begin
          valid_bit    = 1'b1;
          dirty_bit    = 1'b0;
          data0_write  = !r_victim;
          tag0_write   = !r_victim;
          valid0_write = !r_victim;
          dirty0_write = !r_victim;
          data1_write  = r_victim;
          tag1_write   = r_victim;
          valid1_write = r_victim;
          dirty1_write = r_victim;
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk     (clk),
    .rst     (reset),
    .i_inc   (w_hit_inc),
    .o_count (hit_count)
  );

  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk     (clk),
    .rst     (reset),
    .i_inc   (w_miss_inc),
    .o_count (miss_count)
  );

  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk     (clk),
    .rst     (reset),
    .i_inc   (w_wb_inc),
    .o_count (wb_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: drives datapath status bits directly and
// compares control outputs against hand-computed vectors.
module tb_cache_control;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic        mem_resp;
  logic        hit0, hit1, valid_out0, valid_out1, dirty_out0, dirty_out1, lru_out;
  logic [8:0]  cache_tag;
  logic [2:0]  cache_index;
  logic [3:0]  cache_offset;
  logic        inmux_sel, hitmux_sel, pmem_addr_sel;
  logic        data0_write, data1_write, tag0_write, tag1_write;
  logic        valid0_write, valid1_write, dirty0_write, dirty1_write;
  logic        lru_write, lru_bit, valid_bit, dirty_bit;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [15:0] hit_count, miss_count, wb_count;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  // we_v:  data0 data1 tag0 tag1 valid0 valid1 dirty0 dirty1 lru
  // ctl_v: mem_resp inmux hitmux paddr pmem_read pmem_write lru_bit valid_bit dirty_bit
  logic [8:0] we_v;
  logic [8:0] ctl_v;
  assign we_v  = {data0_write, data1_write, tag0_write, tag1_write, valid0_write,
                  valid1_write, dirty0_write, dirty1_write, lru_write};
  assign ctl_v = {mem_resp, inmux_sel, hitmux_sel, pmem_addr_sel, pmem_read,
                  pmem_write, lru_bit, valid_bit, dirty_bit};

  cache_control #(.CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_resp(mem_resp),
    .hit0(hit0), .hit1(hit1), .valid_out0(valid_out0), .valid_out1(valid_out1),
    .dirty_out0(dirty_out0), .dirty_out1(dirty_out1), .lru_out(lru_out),
    .cache_tag(cache_tag), .cache_index(cache_index), .cache_offset(cache_offset),
    .inmux_sel(inmux_sel), .hitmux_sel(hitmux_sel), .pmem_addr_sel(pmem_addr_sel),
    .data0_write(data0_write), .data1_write(data1_write),
    .tag0_write(tag0_write), .tag1_write(tag1_write),
    .valid0_write(valid0_write), .valid1_write(valid1_write),
    .dirty0_write(dirty0_write), .dirty1_write(dirty1_write),
    .lru_write(lru_write), .lru_bit(lru_bit), .valid_bit(valid_bit),
    .dirty_bit(dirty_bit), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .hit_count(hit_count), .miss_count(miss_count),
    .wb_count(wb_count), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_status(input logic h0, input logic h1, input logic v0,
                              input logic v1, input logic d0, input logic d1,
                              input logic lru);
    hit0 = h0; hit1 = h1; valid_out0 = v0; valid_out1 = v1;
    dirty_out0 = d0; dirty_out1 = d1; lru_out = lru;
    #1;
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic [15:0] addr);
    mem_read = rd; mem_write = wr; mem_address = addr;
    #1;
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1;
    drive_req(1'b0, 1'b0, 16'h1234);
    drive_status(0, 0, 0, 0, 0, 0, 0);
    pmem_resp = 1'b0;
    repeat (2) tick();
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    checks++; if (we_v !== 9'b0) begin failures++; $display("FAIL reset_we got=%b exp=%b", we_v, 9'b0); end
    checks++; if (ctl_v !== 9'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl_v, 9'b0); end
    checks++; if ({hit_count, miss_count, wb_count} !== 48'h0) begin failures++; $display("FAIL reset_counters got=%h exp=0", {hit_count, miss_count, wb_count}); end
    checks++; if ({cache_tag, cache_index, cache_offset} !== {9'h024, 3'd3, 4'h4}) begin failures++; $display("FAIL addr_split got=%h/%h/%h exp=024/3/4", cache_tag, cache_index, cache_offset); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_cold_read();
    drive_req(1'b1, 1'b0, 16'h1234);
    checks++; if ({ctl_v, we_v} !== 18'b0) begin failures++; $display("FAIL cold_idle got=%b exp=0", {ctl_v, we_v}); end
    tick();
    checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL cold_state got=%0d exp=2", dbg_state); end
    checks++; if (ctl_v !== 9'b000010000) begin failures++; $display("FAIL cold_fill_ctl got=%b exp=000010000", ctl_v); end
    checks++; if (miss_count !== 16'd1) begin failures++; $display("FAIL cold_miss_cnt got=%0d exp=1", miss_count); end
    tick();
    checks++; if ({dbg_state, we_v} !== {2'd2, 9'b0}) begin failures++; $display("FAIL cold_wait got=%0d/%b exp=2/0", dbg_state, we_v); end
    pmem_resp = 1'b1; #1;
    checks++; if (we_v !== 9'b101010100) begin failures++; $display("FAIL cold_fill_we got=%b exp=101010100", we_v); end
    checks++; if (ctl_v !== 9'b000010010) begin failures++; $display("FAIL cold_fill_bits got=%b exp=000010010", ctl_v); end
    tick();
    pmem_resp = 1'b0;
    drive_status(1, 0, 1, 0, 0, 0, 0);
    checks++; if (ctl_v !== 9'b101000100) begin failures++; $display("FAIL cold_rehit_ctl got=%b exp=101000100", ctl_v); end
    checks++; if (we_v !== 9'b000000001) begin failures++; $display("FAIL cold_rehit_we got=%b exp=000000001", we_v); end
    tick();
    checks++; if ({hit_count, miss_count, wb_count} !== {16'd1, 16'd1, 16'd0}) begin failures++; $display("FAIL cold_counts got=%0d/%0d/%0d exp=1/1/0", hit_count, miss_count, wb_count); end
  endtask

  task automatic test_read_hit();
    drive_req(1'b1, 1'b0, 16'h1236);
    checks++; if (ctl_v !== 9'b101000100) begin failures++; $display("FAIL rdhit_ctl got=%b exp=101000100", ctl_v); end
    checks++; if (we_v !== 9'b000000001) begin failures++; $display("FAIL rdhit_we got=%b exp=000000001", we_v); end
    tick();
    checks++; if ({dbg_state, hit_count} !== {2'd0, 16'd2}) begin failures++; $display("FAIL rdhit_after got=%0d/%0d exp=0/2", dbg_state, hit_count); end
  endtask

  task automatic test_write_hit();
    drive_req(1'b0, 1'b1, 16'h1230);
    checks++; if (ctl_v !== 9'b111000101) begin failures++; $display("FAIL wrhit0_ctl got=%b exp=111000101", ctl_v); end
    checks++; if (we_v !== 9'b100000101) begin failures++; $display("FAIL wrhit0_we got=%b exp=100000101", we_v); end
    tick();
    // read and write together count as a write; hit on way 1 this time
    drive_req(1'b1, 1'b1, 16'h1230);
    drive_status(0, 1, 0, 1, 0, 0, 0);
    checks++; if (ctl_v !== 9'b110000001) begin failures++; $display("FAIL wrhit1_ctl got=%b exp=110000001", ctl_v); end
    checks++; if (we_v !== 9'b010000011) begin failures++; $display("FAIL wrhit1_we got=%b exp=010000011", we_v); end
    tick();
    checks++; if ({hit_count, miss_count} !== {16'd4, 16'd1}) begin failures++; $display("FAIL wrhit_counts got=%0d/%0d exp=4/1", hit_count, miss_count); end
  endtask

  task automatic test_victim_invalid_way1();
    // tag match on invalid way 1 is a miss; way 1 empty so no writeback
    drive_req(1'b1, 1'b0, 16'h2240);
    drive_status(0, 1, 1, 0, 1, 0, 0);
    checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL inval_hit_resp got=%b exp=0", mem_resp); end
    tick();
    checks++; if ({dbg_state, ctl_v} !== {2'd2, 9'b000010000}) begin failures++; $display("FAIL inval_fill got=%0d/%b exp=2/000010000", dbg_state, ctl_v); end
    drive_req(1'b0, 1'b0, 16'h2240);
    pmem_resp = 1'b1; #1;
    checks++; if (we_v !== 9'b010101010) begin failures++; $display("FAIL inval_fill_we got=%b exp=010101010", we_v); end
    tick();
    pmem_resp = 1'b0; #1;
    checks++; if ({dbg_state, ctl_v, we_v} !== {2'd0, 18'b0}) begin failures++; $display("FAIL dropped_req got=%0d/%b/%b exp=0/0/0", dbg_state, ctl_v, we_v); end
    tick();
    checks++; if ({hit_count, miss_count} !== {16'd4, 16'd2}) begin failures++; $display("FAIL dropped_counts got=%0d/%0d exp=4/2", hit_count, miss_count); end
  endtask

  task automatic test_writeback(input logic lru, input logic [8:0] wb_ctl,
                                input logic [8:0] fill_we, input logic [15:0] exp_wb);
    drive_req(1'b1, 1'b0, 16'h5A30);
    drive_status(0, 0, 1, 1, !lru, lru, lru);
    tick();
    checks++; if ({dbg_state, ctl_v} !== {2'd1, wb_ctl}) begin failures++; $display("FAIL wb_ctl got=%0d/%b exp=1/%b", dbg_state, ctl_v, wb_ctl); end
    tick();
    checks++; if ({dbg_state, we_v} !== {2'd1, 9'b0}) begin failures++; $display("FAIL wb_hold got=%0d/%b exp=1/0", dbg_state, we_v); end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; #1;
    checks++; if ({dbg_state, ctl_v, wb_count} !== {2'd2, 9'b000010000, exp_wb}) begin failures++; $display("FAIL wb_to_fill got=%0d/%b/%0d exp=2/000010000/%0d", dbg_state, ctl_v, wb_count, exp_wb); end
    pmem_resp = 1'b1; #1;
    checks++; if (we_v !== fill_we) begin failures++; $display("FAIL wb_fill_we got=%b exp=%b", we_v, fill_we); end
    tick();
    pmem_resp = 1'b0;
    drive_status(!lru, lru, 1, 1, 0, 0, lru);
    checks++; if (mem_resp !== 1'b1) begin failures++; $display("FAIL wb_rehit got=%b exp=1", mem_resp); end
    tick();
    drive_req(1'b0, 1'b0, 16'h5A30);
  endtask

  task automatic test_stray_pmem_resp();
    pmem_resp = 1'b1;
    drive_status(0, 0, 1, 1, 1, 1, 0);
    checks++; if ({ctl_v, we_v} !== 18'b0) begin failures++; $display("FAIL stray_resp_out got=%b exp=0", {ctl_v, we_v}); end
    tick();
    pmem_resp = 1'b0; #1;
    checks++; if ({dbg_state, hit_count, miss_count, wb_count} !== {2'd0, 16'd6, 16'd4, 16'd2}) begin failures++; $display("FAIL stray_resp_state got=%0d/%0d/%0d/%0d exp=0/6/4/2", dbg_state, hit_count, miss_count, wb_count); end
  endtask

  task automatic test_reset_mid_fill();
    drive_req(1'b1, 1'b0, 16'h7770);
    drive_status(0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL rst_pre_fill got=%b exp=1", pmem_read); end
    reset = 1'b1; #1;
    checks++; if ({pmem_read, pmem_write, dbg_state} !== 4'b0000) begin failures++; $display("FAIL rst_abort got=%b%b/%0d exp=00/0", pmem_read, pmem_write, dbg_state); end
    checks++; if ({hit_count, miss_count, wb_count} !== 48'h0) begin failures++; $display("FAIL rst_counters got=%h exp=0", {hit_count, miss_count, wb_count}); end
    drive_req(1'b0, 1'b0, 16'h7770);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    drive_req(1'b1, 1'b0, 16'h1234);
    drive_status(1, 0, 1, 0, 0, 0, 0);
    repeat (65534) tick();
    checks++; if (hit_count !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=FFFE", hit_count); end
    repeat (5) tick();
    checks++; if (hit_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=FFFF", hit_count); end
    checks++; if ({miss_count, wb_count} !== 32'h0) begin failures++; $display("FAIL sat_others got=%h exp=0", {miss_count, wb_count}); end
    drive_req(1'b0, 1'b0, 16'h1234);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pmem_resp = 1'b0;
    test_reset();
    test_cold_read();
    test_read_hit();
    test_write_hit();
    test_victim_invalid_way1();
    test_writeback(1'b0, 9'b001101000, 9'b101010100, 16'd1);
    test_writeback(1'b1, 9'b000101000, 9'b010101010, 16'd2);
    test_stray_pmem_resp();
    test_reset_mid_fill();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
